// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU engine: op codes, FSM states,
// and small op-classification helpers.
package alu_serial_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op[3] == 1'b0) && (op[2:0] != 3'b111);
    endfunction

    function automatic logic op_is_cmp(input logic [3:0] op);
        return (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || op_is_cmp(op);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational classification of an incoming op code.
module alu_op_decode
    import alu_serial_pkg::*;
(
    input  logic [3:0] op,
    output logic       legal,
    output logic       cin_init,
    output logic       is_arith,
    output logic       is_cmp
);

    always_comb begin
        legal    = op_legal(op);
        // Subtraction-based ops (SUB/SLT/SLTU) all have op[2]=1 and need cin=1.
        cin_init = legal & op[2];
        is_arith = op_is_arith(op);
        is_cmp   = op_is_cmp(op);
    end

endmodule

// File: rtl/alu_serial_engine.sv
// Drives an external 1-bit ALU slice LSB-first for WIDTH cycles, chaining the
// carry through a register, and returns the assembled result with flags.
module alu_serial_engine
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             slice_a,
    output logic             slice_b,
    output logic [3:0]       slice_op,
    output logic             slice_cin,
    input  logic             slice_sum,
    input  logic             slice_cout,
    input  logic             slice_ovf,
    input  logic             slice_set
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg, result_reg, result_next;
    logic [3:0]         op_reg;
    logic               carry_reg;
    logic               arith_reg, cmp_reg;
    logic [CNT_W-1:0]   bit_reg;

    logic               dec_legal, dec_cin, dec_arith, dec_cmp;
    logic               accept, last_bit;
    logic [WIDTH-1:0]   final_result;

    alu_op_decode u_decode (
        .op       (req_op),
        .legal    (dec_legal),
        .cin_init (dec_cin),
        .is_arith (dec_arith),
        .is_cmp   (dec_cmp)
    );

    assign accept   = (state_reg == IDLE) && req_valid;
    assign last_bit = (state_reg == RUN) && (bit_reg == LAST_BIT);

    // Merge the current slice bit into the partial result.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
            assign result_next[gi] = ((state_reg == RUN) && (bit_reg == CNT_W'(gi)))
                                     ? slice_sum : result_reg[gi];
        end
    endgenerate

    assign final_result = cmp_reg ? {{(WIDTH-1){1'b0}}, slice_set} : result_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_op   = 4'b0000;
        slice_cin  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = dec_legal ? RUN : DONE;
            end
            RUN: begin
                slice_a   = a_reg[bit_reg];
                slice_b   = b_reg[bit_reg];
                slice_op  = op_reg;
                slice_cin = carry_reg;
                if (bit_reg == LAST_BIT) state_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= 4'b0000;
            carry_reg    <= 1'b0;
            arith_reg    <= 1'b0;
            cmp_reg      <= 1'b0;
            bit_reg      <= '0;
            result_reg   <= '0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b0;
        end else if (accept) begin
            // Illegal ops report err with every other flag cleared, zero included.
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= ~dec_legal;
            if (dec_legal) begin
                a_reg      <= req_a;
                b_reg      <= req_b;
                op_reg     <= req_op;
                carry_reg  <= dec_cin;
                arith_reg  <= dec_arith;
                cmp_reg    <= dec_cmp;
                bit_reg    <= '0;
                result_reg <= '0;
            end
        end else if (state_reg == RUN) begin
            result_reg <= result_next;
            carry_reg  <= slice_cout;
            if (last_bit) begin
                bit_reg      <= '0;
                rsp_result   <= final_result;
                rsp_carry    <= arith_reg & slice_cout;
                rsp_overflow <= arith_reg & slice_ovf;
                rsp_zero     <= (final_result == '0);
            end else begin
                bit_reg <= bit_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_engine.sv
// Randomized and directed bench for alu_serial_engine (WIDTH=8) with a
// behavioural model of the external 1-bit slice and an arithmetic reference.
module tb_alu_serial_engine;
    import alu_serial_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = 4'b0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_overflow, rsp_zero, rsp_err;
    logic         slice_a, slice_b, slice_cin;
    logic [3:0]   slice_op;
    logic         slice_sum, slice_cout, slice_ovf, slice_set;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_serial_engine #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err),
        .slice_a(slice_a), .slice_b(slice_b), .slice_op(slice_op), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_cout(slice_cout), .slice_ovf(slice_ovf),
        .slice_set(slice_set)
    );

    // External MSB slice; logic ops drive junk carry/overflow the engine must mask.
    logic bb;
    always_comb begin
        slice_sum  = 1'b0;
        slice_cout = 1'b1;
        slice_ovf  = 1'b1;
        slice_set  = 1'b1;
        bb         = slice_b;
        case (slice_op)
            4'b0000: slice_sum = slice_a & slice_b;
            4'b0001: slice_sum = slice_a | slice_b;
            4'b0010: slice_sum = slice_a ^ slice_b;
            4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
                bb         = (slice_op == 4'b0011) ? slice_b : ~slice_b;
                slice_sum  = slice_a ^ bb ^ slice_cin;
                slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
                slice_ovf  = slice_cin ^ slice_cout;
                slice_set  = (slice_op == 4'b0101) ? (slice_sum ^ slice_ovf)
                           : (slice_op == 4'b0110) ? ~slice_cout : 1'b0;
            end
            default: ;
        endcase
    end

    function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] r,
                                      output logic c, output logic v, output logic z,
                                      output logic e);
        logic [W:0] s;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            4'd4, 4'd5, 4'd6: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                c = s[W];
                v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
                if (op == 4'd4)      r = s[W-1:0];
                else if (op == 4'd5) r = ($signed(a) < $signed(b)) ? 1 : 0;
                else                 r = (a < b) ? 1 : 0;
            end
            default: e = 1'b1;
        endcase
        z = (r == 0) && !e;
    endfunction

    // One request/response transaction; hold = cycles of backpressure in DONE.
    task automatic run_txn(input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic ec, ev, ez, ee;
        int edges;
        int exp_lat;
        ref_model(op, a, b, er, ec, ev, ez, ee);
        exp_lat = ee ? 1 : W + 1;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        edges = 1;
        if (!ee) begin
            n_cmp++;
            if (slice_cin !== op[2]) begin n_bad++; $display("FAIL first_cin op=%h: got %b want %b", op, slice_cin, op[2]); end
        end
        while (rsp_valid !== 1'b1 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        n_cmp++;
        if (edges != exp_lat) begin n_bad++; $display("FAIL latency op=%h: got %0d want %0d", op, edges, exp_lat); end
        repeat (hold) @(posedge clk);
        #1;
        n_cmp++;
        if ({rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err} !== {er, ec, ev, ez, ee}) begin
            n_bad++;
            $display("FAIL rsp op=%h a=%h b=%h: got r=%h c=%b v=%b z=%b e=%b want r=%h c=%b v=%b z=%b e=%b",
                     op, a, b, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err, er, ec, ev, ez, ee);
        end
        $display("txn op=%h a=%h b=%h -> r=%h c=%b v=%b z=%b e=%b lat=%0d",
                 op, a, b, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err, edges);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rsp_valid_drop: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL reset_hs: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        n_cmp++;
        if ({rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err} !== '0) begin
            n_bad++; $display("FAIL reset_rsp: got r=%h flags=%b%b%b%b want 0", rsp_result,
                              rsp_carry, rsp_overflow, rsp_zero, rsp_err);
        end
        n_cmp++;
        if ({slice_a, slice_b, slice_op, slice_cin} !== 7'b0) begin
            n_bad++; $display("FAIL reset_slice: got %b want 0", {slice_a, slice_b, slice_op, slice_cin});
        end
        $display("reset check done");
    endtask

    task automatic test_directed();
        run_txn(OP_ADD, 8'h7F, 8'h01, 0);
        run_txn(OP_SUB, 8'h05, 8'h05, 0);
        run_txn(OP_SLT, 8'h80, 8'h01, 0);
        run_txn(OP_SLTU, 8'h80, 8'h01, 0);
        run_txn(OP_XOR, 8'hF0, 8'hFF, 0);
        run_txn(OP_AND, 8'hC3, 8'h5A, 0);
        run_txn(OP_OR, 8'h00, 8'h00, 0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] er;
        logic ec, ev, ez, ee;
        int edges;
        ref_model(OP_ADD, 8'h12, 8'h34, er, ec, ev, ez, ee);
        req_valid = 1'b1; req_op = OP_ADD; req_a = 8'h12; req_b = 8'h34;
        @(posedge clk); #1;
        req_op = OP_SUB; req_a = 8'h40; req_b = 8'h41;
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 50) begin @(posedge clk); #1; edges++; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, er}) begin
                n_bad++; $display("FAIL bp_hold cyc%0d: got v=%b rdy=%b r=%h want 1/0/%h",
                                  i, rsp_valid, req_ready, rsp_result, er);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hs_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_bad++; $display("FAIL bp_after_hs: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept: got rdy=%b want 0", req_ready); end
        ref_model(OP_SUB, 8'h40, 8'h41, er, ec, ev, ez, ee);
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 50) begin @(posedge clk); #1; edges++; end
        n_cmp++;
        if ({rsp_result, rsp_carry, rsp_overflow, edges} !== {er, ec, ev, W + 1}) begin
            n_bad++; $display("FAIL bp_second: got r=%h c=%b v=%b lat=%0d want r=%h c=%b v=%b lat=%0d",
                              rsp_result, rsp_carry, rsp_overflow, edges, er, ec, ev, W + 1);
        end
        $display("txn backpressure ADD then SUB -> r=%h", rsp_result);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_illegal();
        run_txn(4'b0111, 8'hAA, 8'h55, 0);
        run_txn(4'b1011, 8'h01, 8'h02, 2);
        run_txn(OP_ADD, 8'h10, 8'h20, 0);
    endtask

    task automatic test_reset_mid_run();
        req_valid = 1'b1; req_op = OP_ADD; req_a = 8'hFF; req_b = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready, slice_a, slice_b, slice_cin} !== 5'b01000) begin
            n_bad++; $display("FAIL mid_reset: got v=%b rdy=%b sa=%b sb=%b cin=%b want 0/1/0/0/0",
                              rsp_valid, req_ready, slice_a, slice_b, slice_cin);
        end
        $display("txn mid-run reset applied");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(OP_ADD, 8'h03, 8'h04, 0);
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(7, 15));
            else                           op = 4'($urandom_range(0, 6));
            run_txn(op, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_backpressure();
        test_illegal();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_engine.md
Name: alu_serial_engine

Overview:
Multi-cycle initiator that drives a single external 1-bit ALU MSB slice (A, B, Op, Carryin in; usum, Carryout, Overflow, Set out) LSB-first, one bit per cycle, to produce a full WIDTH-bit result.
Accepts operation requests over a valid/ready handshake, chains the slice carry through a register, and captures Overflow/Set on the final (MSB) bit.
Returns result and flags over a second valid/ready handshake.
Serves the area-reduced datapath variant of the single-cycle processor.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), bit-index counter width (derived; not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  engine can accept request
req_op  in  4  operation code (see Behaviour)
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  result
rsp_carry  out  1  final carry-out (arith ops), else 0
rsp_overflow  out  1  signed overflow (arith ops), else 0
rsp_zero  out  1  rsp_result == 0
rsp_err  out  1  illegal op code
slice_a  out  1  to slice A
slice_b  out  1  to slice B
slice_op  out  4  to slice Op
slice_cin  out  1  to slice Carryin
slice_sum  in  1  from slice usum
slice_cout  in  1  from slice Carryout
slice_ovf  in  1  from slice Overflow
slice_set  in  1  from slice Set

Behaviour:
- Op codes: 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB, 0101 SLT, 0110 SLTU. 0111 and any op with bit3=1 are illegal.
- Reset (async, rst_n=0): state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; all rsp flags 0; slice_* outputs 0; counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid with a legal op: latch a, b, op; bit=0; carry_q=op[2]; go to RUN.
  - On req_valid with an illegal op: go to DONE with rsp_err=1, result 0, all flags 0 (latency 1 cycle).
- RUN:
  - req_ready=0.
  - Drive combinationally: slice_a=a_q[bit], slice_b=b_q[bit], slice_op=op_q, slice_cin=carry_q.
  - Each edge: result_q[bit]<=slice_sum; carry_q<=slice_cout; bit<=bit+1.
  - At bit==WIDTH-1 the edge also captures rsp_carry<=slice_cout, rsp_overflow<=slice_ovf, set_q<=slice_set; next state DONE.
  - RUN lasts exactly WIDTH cycles.
- Outside RUN, slice_* outputs are all 0.
- DONE:
  - rsp_valid=1; outputs held stable until rsp_valid && rsp_ready; then return to IDLE (rsp_valid=0 next cycle).
  - Response latency: rsp_valid rises WIDTH+1 edges after the accepting edge.
  - No new request is accepted in RUN or DONE.
- SLT/SLTU: rsp_result = {(WIDTH-1)'b0, set_q}. rsp_carry/rsp_overflow report the underlying subtraction.
- Logic ops: rsp_carry=0, rsp_overflow=0 (forced by the engine regardless of slice inputs).
- rsp_zero computed from final rsp_result, registered with it.
- Carry/bit counter never wraps. bit saturates to 0 on entry to DONE.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE; partial result discarded; rsp_valid drops asynchronously.
- req_valid while rsp_valid=1 and rsp_ready=1: not accepted this cycle (req_ready=0). Accepted earliest the following cycle.

Decomposition:
- Package alu_serial_pkg:
  - op-code localparams (OP_AND..OP_SLTU)
  - state enum (IDLE/RUN/DONE)
  - helper functions op_is_arith(op), op_is_cmp(op), op_legal(op)
- One sub-module, alu_op_decode (combinational): req_op -> legal, initial carry-in, is_arith, is_cmp.
- The bit-slice itself stays outside this block, connected via the slice_* ports.

Test Plan:
- WIDTH=8, ADD 0x7F+0x01 -> rsp_valid 9 edges after accept; result 0x80, overflow=1, carry=0, zero=0.
- WIDTH=8, SUB 0x05-0x05 -> result 0x00, zero=1, carry=1, overflow=0. Confirm slice_cin=1 on the first RUN cycle.
- WIDTH=8, SLT a=0x80 b=0x01 -> result 0x01. SLTU same operands -> result 0x00. XOR 0xF0^0xFF -> 0x0F, carry=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> outputs stable, req_ready=0. Next request is accepted only after the response handshake.
- Illegal op 0111 and 1011 -> rsp_valid after 1 cycle, rsp_err=1, result 0. A following legal ADD completes normally with err=0.
- Assert rst_n=0 at RUN bit 3 -> rsp_valid=0 and req_ready=1 immediately. A new ADD 3+4 then yields 0x07 with no residue.
